// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encoding and helpers
// for the instruction-fetch stage.
package inst_fetch_pkg;

   localparam int          REG_BUS      = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_REQ   = 2'd1,
      IF_WAIT  = 2'd2,
      IF_DRAIN = 2'd3
   } if_state_e;

   function automatic logic is_misaligned(
      input logic [REG_BUS-1:0] a
   );
      return a[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read bus:
// req/gnt request phase, rvalid data phase.
interface inst_fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/inst_fetch_timer.sv
// Grant-to-rvalid watchdog: clearable counter
// flagging expiry on its last cycle.
module fetch_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] r_cnt;

   // count cycles since the grant
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, imem handshake
// FSM and instruction register.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] NOP_INST = INST_NOP
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_fetch_en,
   input  logic               i_pc_we,
   input  logic               i_jump,
   input  logic [REG_BUS-1:0] i_jump_addr,
   inst_fetch_if.master       bus,
   output logic [REG_BUS-1:0] o_inst,
   output logic [REG_BUS-1:0] o_pc,
   output logic               o_inst_valid,
   output logic               o_hold,
   output logic               o_misalign,
   output logic               o_bus_err
);

   if_state_e          r_state;
   logic [REG_BUS-1:0] r_pc;
   logic [REG_BUS-1:0] r_inst;
   logic [REG_BUS-1:0] r_addr;
   logic               r_req;
   logic               r_inst_valid;
   logic               r_misalign;
   logic               r_bus_err;

   logic [REG_BUS-1:0] w_pc_nxt;
   logic               w_bad_jump;
   logic               w_tmr_clr;
   logic               w_tmr_en;
   logic               w_expired;

   // next PC; a misaligned target leaves PC alone
   always_comb begin
      w_bad_jump = i_jump && is_misaligned(i_jump_addr);
      w_pc_nxt   = r_pc + 32'd4;
      if (i_jump) begin
         w_pc_nxt = w_bad_jump ? r_pc : i_jump_addr;
      end
   end

   // PC register and sticky misalign flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc       <= RESET_PC;
         r_misalign <= 1'b0;
      end else if (i_pc_we) begin
         r_pc <= w_pc_nxt;
         if (w_bad_jump) begin
            r_misalign <= 1'b1;
         end
      end
   end

   assign w_tmr_clr = (r_state == IF_REQ) && bus.imem_gnt;
   assign w_tmr_en  = (r_state == IF_WAIT) ||
                      (r_state == IF_DRAIN);

   fetch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rstn      (rstn),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   // fetch FSM with registered bus and IR outputs;
   // data arriving after a PC commit is stale
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= IF_IDLE;
         r_req        <= 1'b0;
         r_addr       <= RESET_PC;
         r_inst       <= NOP_INST;
         r_inst_valid <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_inst_valid <= 1'b0;
         unique case (r_state)
            IF_IDLE: begin
               if (i_fetch_en && !r_misalign && !r_bus_err) begin
                  r_state <= IF_REQ;
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
               end
            end
            IF_REQ: begin
               if (bus.imem_gnt) begin
                  r_req <= 1'b0;
                  if (bus.imem_rvalid) begin
                     r_state <= IF_IDLE;
                     if (!i_pc_we) begin
                        r_inst       <= bus.imem_rdata;
                        r_inst_valid <= 1'b1;
                     end
                  end else begin
                     r_state <= i_pc_we ? IF_DRAIN : IF_WAIT;
                  end
               end else if (i_pc_we) begin
                  r_addr <= w_pc_nxt;
               end
            end
            IF_WAIT: begin
               if (bus.imem_rvalid) begin
                  r_state <= IF_IDLE;
                  if (!i_pc_we) begin
                     r_inst       <= bus.imem_rdata;
                     r_inst_valid <= 1'b1;
                  end
               end else if (w_expired) begin
                  r_state   <= IF_IDLE;
                  r_bus_err <= 1'b1;
               end else if (i_pc_we) begin
                  r_state <= IF_DRAIN;
               end
            end
            IF_DRAIN: begin
               if (bus.imem_rvalid) begin
                  r_state <= IF_IDLE;
               end else if (w_expired) begin
                  r_state   <= IF_IDLE;
                  r_bus_err <= 1'b1;
               end
            end
            default: r_state <= IF_IDLE;
         endcase
      end
   end

   assign bus.imem_req  = r_req;
   assign bus.imem_addr = r_addr;
   assign o_inst        = r_inst;
   assign o_pc          = r_pc;
   assign o_inst_valid  = r_inst_valid;
   assign o_hold        = (r_state != IF_IDLE);
   assign o_misalign    = r_misalign;
   assign o_bus_err     = r_bus_err;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a
// scoreboard of expected instruction words.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        fetch_en = 1'b0;
   logic        pc_we = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] jump_addr = 32'h0;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        hold;
   logic        misalign;
   logic        bus_err;

   int          n_checks = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   inst_fetch_if bus();

   inst_fetch dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_fetch_en   (fetch_en),
      .i_pc_we      (pc_we),
      .i_jump       (jump),
      .i_jump_addr  (jump_addr),
      .bus          (bus),
      .o_inst       (inst),
      .o_pc         (pc),
      .o_inst_valid (inst_valid),
      .o_hold       (hold),
      .o_misalign   (misalign),
      .o_bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every inst_valid pulse consumes one expected word
   always @(negedge clk) begin
      if (rstn && inst_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("sb_inst", inst, exp_q.pop_front());
         end
      end
   end

   initial begin
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      step();
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h13);
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_hold", {31'd0, hold}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);

      // minimum-latency fetch
      rstn = 1'b1;
      fetch_en = 1'b1;
      step();
      chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t1_addr", bus.imem_addr, 32'h0);
      chk("t1_hold_a", {31'd0, hold}, 32'd1);
      fetch_en = 1'b0;
      bus.imem_gnt = 1'b1;
      step();
      chk("t1_req_drop", {31'd0, bus.imem_req}, 32'd0);
      chk("t1_hold_b", {31'd0, hold}, 32'd1);
      chk("t1_valid_early", {31'd0, inst_valid}, 32'd0);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h0050_0093;
      exp_q.push_back(32'h0050_0093);
      step();
      chk("t1_valid", {31'd0, inst_valid}, 32'd1);
      chk("t1_inst", inst, 32'h0050_0093);
      chk("t1_hold_c", {31'd0, hold}, 32'd0);
      bus.imem_rvalid = 1'b0;
      step();
      chk("t1_pulse", {31'd0, inst_valid}, 32'd0);

      // delayed grant
      pc_we = 1'b1;
      step();
      chk("t2_pc", pc, 32'h4);
      pc_we = 1'b0;
      fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_req_stable", {31'd0, bus.imem_req}, 32'd1);
         chk("t2_addr_stable", bus.imem_addr, 32'h4);
         step();
      end
      bus.imem_gnt = 1'b1;
      step();
      chk("t2_req_drop", {31'd0, bus.imem_req}, 32'd0);
      bus.imem_gnt = 1'b0;
      step();
      chk("t2_wait_hold", {31'd0, hold}, 32'd1);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h1234_5678;
      exp_q.push_back(32'h1234_5678);
      step();
      chk("t2_valid", {31'd0, inst_valid}, 32'd1);
      chk("t2_inst", inst, 32'h1234_5678);
      bus.imem_rdata = 32'hAAAA_AAAA;
      step();
      chk("idle_rvalid_valid", {31'd0, inst_valid}, 32'd0);
      chk("idle_rvalid_inst", inst, 32'h1234_5678);
      chk("idle_rvalid_hold", {31'd0, hold}, 32'd0);
      bus.imem_rvalid = 1'b0;

      // retarget while waiting for grant
      fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      pc_we = 1'b1;
      jump = 1'b1;
      jump_addr = 32'h40;
      step();
      chk("t3_addr", bus.imem_addr, 32'h40);
      chk("t3_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t3_pc", pc, 32'h40);
      pc_we = 1'b0;
      jump = 1'b0;
      bus.imem_gnt = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h0BAD_F00D;
      exp_q.push_back(32'h0BAD_F00D);
      step();
      chk("t3_inst", inst, 32'h0BAD_F00D);
      chk("t3_hold", {31'd0, hold}, 32'd0);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;

      // PC wrap and jump
      pc_we = 1'b1;
      jump = 1'b1;
      jump_addr = 32'hFFFF_FFFC;
      step();
      chk("t4_pc_top", pc, 32'hFFFF_FFFC);
      jump = 1'b0;
      step();
      chk("t4_pc_wrap", pc, 32'h0);
      jump = 1'b1;
      jump_addr = 32'h80;
      step();
      chk("t4_pc_jump", pc, 32'h80);
      pc_we = 1'b0;
      jump = 1'b0;
      fetch_en = 1'b1;
      step();
      chk("t4_addr", bus.imem_addr, 32'h80);
      fetch_en = 1'b0;
      bus.imem_gnt = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h1111_1111;
      exp_q.push_back(32'h1111_1111);
      step();
      chk("t4_inst", inst, 32'h1111_1111);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;

      // PC commit mid-fetch drains the stale word
      fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt = 1'b0;
      pc_we = 1'b1;
      step();
      chk("t5_pc", pc, 32'h84);
      chk("t5_hold", {31'd0, hold}, 32'd1);
      pc_we = 1'b0;
      step();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("t5_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("t5_inst_kept", inst, 32'h1111_1111);
      chk("t5_idle", {31'd0, hold}, 32'd0);
      bus.imem_rvalid = 1'b0;
      fetch_en = 1'b1;
      step();
      chk("t5_new_addr", bus.imem_addr, 32'h84);
      fetch_en = 1'b0;
      bus.imem_gnt = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h2222_2222;
      exp_q.push_back(32'h2222_2222);
      step();
      chk("t5_inst", inst, 32'h2222_2222);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;

      // asynchronous reset in the middle of WAIT
      fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt = 1'b0;
      step();
      chk("t6_in_wait", {31'd0, hold}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t6_pc", pc, 32'h0);
      chk("t6_inst", inst, 32'h13);
      chk("t6_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t6_addr", bus.imem_addr, 32'h0);
      chk("t6_hold", {31'd0, hold}, 32'd0);
      chk("t6_valid", {31'd0, inst_valid}, 32'd0);
      step();
      rstn = 1'b1;

      // misaligned jump target
      pc_we = 1'b1;
      jump = 1'b1;
      jump_addr = 32'h82;
      step();
      chk("t7_misalign", {31'd0, misalign}, 32'd1);
      chk("t7_pc", pc, 32'h0);
      pc_we = 1'b0;
      jump = 1'b0;
      fetch_en = 1'b1;
      step();
      step();
      chk("t7_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t7_hold", {31'd0, hold}, 32'd0);
      fetch_en = 1'b0;

      // rvalid timeout
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("t8_misalign_clr", {31'd0, misalign}, 32'd0);
      fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt = 1'b0;
      repeat (15) step();
      chk("t8_not_yet", {31'd0, bus_err}, 32'd0);
      chk("t8_hold_wait", {31'd0, hold}, 32'd1);
      step();
      chk("t8_bus_err", {31'd0, bus_err}, 32'd1);
      chk("t8_hold", {31'd0, hold}, 32'd0);
      chk("t8_inst", inst, 32'h13);
      fetch_en = 1'b1;
      step();
      chk("t8_blocked", {31'd0, bus.imem_req}, 32'd0);
      fetch_en = 1'b0;
      step();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
